// File: rtl/mem_write_checker_pkg.sv
// Shared definitions for the memory write checker: state encoding and default watch address.
package mem_write_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TOUT = 3'd4
  } chk_state_e;

  // Historical single-check location ("address FF must receive 0D").
  localparam logic [7:0] DEF_WATCH_ADR = 8'hFF;

endpackage

// File: rtl/mem_write_checker_if.sv
// Memory write bus as seen between mips and mips_mem; the checker only observes it.
interface mem_write_checker_if #(
  parameter int WIDTH = 8
) ();
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;

  modport master (output memwrite, adr, writedata);
  modport slave  (input  memwrite, adr, writedata);
endinterface

// File: rtl/mem_write_checker_chk_table.sv
// Expected-value table: one synchronous write port, one combinational read port.
module chk_table #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int IDXBITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [IDXBITS-1:0] wr_idx,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [IDXBITS-1:0] rd_idx,
  output logic [WIDTH-1:0]   rd_data
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clk) begin
      if (reset)                                mem[g] <= '0;
      else if (we && wr_idx == IDXBITS'(g))     mem[g] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// Self-checking monitor: compares ordered writes to watch_adr against a loaded table
// and reports pass / fail / timeout with diagnostic counters.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int IDXBITS = 2,
  parameter int TIMEOUT = 300,
  parameter int CNTBITS = 16,
  parameter int ERRBITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_write_checker_if.slave   bus,
  input  logic [WIDTH-1:0]     watch_adr,
  input  logic                 exp_we,
  input  logic [IDXBITS-1:0]   exp_idx,
  input  logic [WIDTH-1:0]     exp_data,
  input  logic [IDXBITS:0]     exp_count,
  input  logic                 stop_on_fail,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [IDXBITS:0]     match_cnt,
  output logic [ERRBITS-1:0]   err_cnt,
  output logic [IDXBITS-1:0]   fail_idx,
  output logic [WIDTH-1:0]     fail_data
);

  localparam logic [CNTBITS-1:0] TO_LAST = CNTBITS'(TIMEOUT - 1);
  localparam logic [IDXBITS:0]   DEPTH_C = (IDXBITS + 1)'(DEPTH);

  chk_state_e         state_q, state_d;
  logic [IDXBITS:0]   idx_q, idx_d;
  logic [CNTBITS-1:0] cyc_q, cyc_d;
  logic [IDXBITS:0]   match_d;
  logic [ERRBITS-1:0] err_d;
  logic [IDXBITS-1:0] fidx_d;
  logic [WIDTH-1:0]   fdata_d;
  logic [WIDTH-1:0]   exp_val;
  logic               hit, hit_ok, cnt_legal;

  // Table is only writable while idle, so a run always sees a stable table.
  chk_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXBITS(IDXBITS)) u_tbl (
    .clk     (clk),
    .reset   (reset),
    .we      (exp_we && state_q == ST_IDLE),
    .wr_idx  (exp_idx),
    .wr_data (exp_data),
    .rd_idx  (idx_q[IDXBITS-1:0]),
    .rd_data (exp_val)
  );

  assign hit       = bus.memwrite && (bus.adr == watch_adr);
  assign hit_ok    = (bus.writedata == exp_val);
  assign cnt_legal = (exp_count != '0) && (exp_count <= DEPTH_C);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    match_d = match_cnt;
    err_d   = err_cnt;
    fidx_d  = fail_idx;
    fdata_d = fail_data;
    case (state_q)
      ST_RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (hit) begin
          idx_d = idx_q + 1'b1;
          if (hit_ok) match_d = match_cnt + 1'b1;
          else begin
            if (err_cnt != {ERRBITS{1'b1}}) err_d = err_cnt + 1'b1;
            if (err_cnt == '0) begin
              fidx_d  = idx_q[IDXBITS-1:0];
              fdata_d = bus.writedata;
            end
          end
        end
        // Completion outranks both stop-on-fail and the timeout edge.
        if (hit && idx_d == exp_count)              state_d = (err_d == '0) ? ST_PASS : ST_FAIL;
        else if (hit && !hit_ok && stop_on_fail)    state_d = ST_FAIL;
        else if (cyc_q == TO_LAST)                  state_d = ST_TOUT;
      end
      default: begin
        if (start) begin
          if (cnt_legal) begin
            state_d = ST_RUN;
            idx_d   = '0;
            cyc_d   = '0;
            match_d = '0;
            err_d   = '0;
            fidx_d  = '0;
            fdata_d = '0;
          end else begin
            state_d = ST_FAIL;
            err_d   = {{(ERRBITS-1){1'b0}}, 1'b1};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cyc_q     <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
      fail_idx  <= '0;
      fail_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cyc_q     <= cyc_d;
      match_cnt <= match_d;
      err_cnt   <= err_d;
      fail_idx  <= fidx_d;
      fail_data <= fdata_d;
      busy      <= (state_d == ST_RUN);
      done      <= (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TOUT);
      pass      <= (state_d == ST_PASS);
      timeout   <= (state_d == ST_TOUT);
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Scenario bench for mem_write_checker: directed plan cases plus randomized runs vs. a queue model.
module tb_mem_write_checker;
  import mem_write_checker_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] watch_adr;
  logic         exp_we;
  logic [1:0]   exp_idx;
  logic [W-1:0] exp_data;
  logic [2:0]   exp_count;
  logic         stop_on_fail, start;
  logic         busy, done, pass, timeout;
  logic [2:0]   match_cnt;
  logic [7:0]   err_cnt;
  logic [1:0]   fail_idx;
  logic [W-1:0] fail_data;

  int n_vec = 0;
  int n_err = 0;

  mem_write_checker_if #(.WIDTH(W)) bus ();

  mem_write_checker #(.WIDTH(W), .DEPTH(4), .IDXBITS(2), .TIMEOUT(300),
                      .CNTBITS(16), .ERRBITS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .watch_adr(watch_adr),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .exp_count(exp_count),
    .stop_on_fail(stop_on_fail), .start(start), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .match_cnt(match_cnt), .err_cnt(err_cnt), .fail_idx(fail_idx),
    .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // status nibble {busy,done,pass,timeout}
  localparam logic [3:0] S_IDLE = 4'b0000, S_RUN = 4'b1000, S_PASS = 4'b0110,
                         S_FAIL = 4'b0100, S_TOUT = 4'b0101;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic load(input logic [1:0] i, input logic [7:0] d);
    exp_we = 1'b1; exp_idx = i; exp_data = d; tick(); exp_we = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] cnt, input logic sof);
    exp_count = cnt; stop_on_fail = sof; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic bwrite(input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.memwrite = we; bus.adr = a; bus.writedata = d; tick(); bus.memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_vec++;
    if ({busy, done, pass, timeout, match_cnt, err_cnt, fail_idx, fail_data} !== '0) begin
      n_err++; $display("FAIL reset_outputs got %b%b%b%b m=%0d e=%0d fi=%0d fd=%h want all 0",
                        busy, done, pass, timeout, match_cnt, err_cnt, fail_idx, fail_data);
    end
  endtask

  task automatic test_single_pass();
    do_reset(); load(2'd0, 8'h0D); do_start(3'd1, 1'b0);
    repeat (9) tick();
    n_vec++;
    if ({busy, done, pass, timeout} !== S_RUN) begin
      n_err++; $display("FAIL t1_waiting got %b want %b", {busy, done, pass, timeout}, S_RUN);
    end
    bwrite(1'b1, 8'hFF, 8'h0D);
    n_vec++;
    if ({busy, done, pass, timeout, match_cnt, err_cnt} !== {S_PASS, 3'd1, 8'd0}) begin
      n_err++; $display("FAIL t1_pass got st=%b m=%0d e=%0d want st=0110 m=1 e=0",
                        {busy, done, pass, timeout}, match_cnt, err_cnt);
    end
  endtask

  task automatic test_stop_on_fail();
    do_reset(); load(2'd0, 8'h0D); do_start(3'd1, 1'b1);
    bwrite(1'b1, 8'hFF, 8'h0C);
    n_vec++;
    if ({busy, done, pass, timeout, err_cnt, fail_idx, fail_data} !== {S_FAIL, 8'd1, 2'd0, 8'h0C}) begin
      n_err++; $display("FAIL t2_fail got st=%b e=%0d fi=%0d fd=%h want st=0100 e=1 fi=0 fd=0c",
                        {busy, done, pass, timeout}, err_cnt, fail_idx, fail_data);
    end
  endtask

  task automatic test_multi();
    logic [7:0] tv [4];
    logic [7:0] wv [4];
    tv = '{8'h01, 8'h02, 8'h03, 8'h05};
    wv = '{8'h01, 8'h02, 8'h04, 8'h05};
    do_reset();
    for (int i = 0; i < 4; i++) load(2'(i), tv[i]);
    do_start(3'd4, 1'b0);
    for (int i = 0; i < 3; i++) bwrite(1'b1, 8'hFF, wv[i]);
    n_vec++;
    if ({busy, done, pass, timeout} !== S_RUN) begin
      n_err++; $display("FAIL t3_still_run got %b want %b", {busy, done, pass, timeout}, S_RUN);
    end
    bwrite(1'b1, 8'hFF, wv[3]);
    n_vec++;
    if ({busy, done, pass, timeout, match_cnt, err_cnt, fail_idx, fail_data} !==
        {S_FAIL, 3'd3, 8'd1, 2'd2, 8'h04}) begin
      n_err++; $display("FAIL t3_result got st=%b m=%0d e=%0d fi=%0d fd=%h want 0100 m=3 e=1 fi=2 fd=04",
                        {busy, done, pass, timeout}, match_cnt, err_cnt, fail_idx, fail_data);
    end
  endtask

  task automatic test_timeout();
    do_reset(); load(2'd0, 8'h0D); do_start(3'd1, 1'b0);
    repeat (299) tick();
    n_vec++;
    if ({busy, done, pass, timeout} !== S_RUN) begin
      n_err++; $display("FAIL t4_before got %b want %b", {busy, done, pass, timeout}, S_RUN);
    end
    tick();
    n_vec++;
    if ({busy, done, pass, timeout} !== S_TOUT) begin
      n_err++; $display("FAIL t4_tout got %b want %b", {busy, done, pass, timeout}, S_TOUT);
    end
  endtask

  task automatic test_nonhits_late_pass();
    do_reset(); load(2'd0, 8'h0D); do_start(3'd1, 1'b0);
    bwrite(1'b1, 8'hFE, 8'h0D);
    bwrite(1'b1, 8'h00, 8'h0D);
    bwrite(1'b0, 8'hFF, 8'h0D);
    n_vec++;
    if ({busy, done, pass, timeout, match_cnt, err_cnt} !== {S_RUN, 3'd0, 8'd0}) begin
      n_err++; $display("FAIL t5_nonhit got st=%b m=%0d e=%0d want 1000 m=0 e=0",
                        {busy, done, pass, timeout}, match_cnt, err_cnt);
    end
    repeat (296) tick();
    bwrite(1'b1, 8'hFF, 8'h0D);
    n_vec++;
    if ({busy, done, pass, timeout, match_cnt} !== {S_PASS, 3'd1}) begin
      n_err++; $display("FAIL t5_late_pass got st=%b m=%0d want 0110 m=1",
                        {busy, done, pass, timeout}, match_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset(); load(2'd0, 8'h0D); do_start(3'd2, 1'b0);
    bwrite(1'b1, 8'hFF, 8'h77);
    do_reset();
    n_vec++;
    if ({busy, done, pass, timeout, match_cnt, err_cnt, fail_idx, fail_data} !== '0) begin
      n_err++; $display("FAIL t6_midreset got st=%b m=%0d e=%0d fi=%0d fd=%h want all 0",
                        {busy, done, pass, timeout}, match_cnt, err_cnt, fail_idx, fail_data);
    end
    // table was cleared, so a zero write must now match entry 0
    do_start(3'd1, 1'b0);
    bwrite(1'b1, 8'hFF, 8'h00);
    n_vec++;
    if ({busy, done, pass, timeout} !== S_PASS) begin
      n_err++; $display("FAIL t6_tbl_cleared got %b want %b", {busy, done, pass, timeout}, S_PASS);
    end
  endtask

  task automatic test_exp_we_in_run();
    do_reset(); load(2'd0, 8'h0D); do_start(3'd1, 1'b0);
    load(2'd0, 8'h33);
    bwrite(1'b1, 8'hFF, 8'h0D);
    n_vec++;
    if ({busy, done, pass, timeout, match_cnt} !== {S_PASS, 3'd1}) begin
      n_err++; $display("FAIL t6_we_ignored got st=%b m=%0d want 0110 m=1",
                        {busy, done, pass, timeout}, match_cnt);
    end
  endtask

  task automatic test_bad_count();
    do_reset(); do_start(3'd0, 1'b0);
    n_vec++;
    if ({busy, done, pass, timeout, err_cnt} !== {S_FAIL, 8'd1}) begin
      n_err++; $display("FAIL t6_cnt0 got st=%b e=%0d want 0100 e=1", {busy, done, pass, timeout}, err_cnt);
    end
    // restart from a terminal state with an over-range count
    do_start(3'd5, 1'b0);
    n_vec++;
    if ({busy, done, pass, timeout, err_cnt} !== {S_FAIL, 8'd1}) begin
      n_err++; $display("FAIL t6_cnt5 got st=%b e=%0d want 0100 e=1", {busy, done, pass, timeout}, err_cnt);
    end
  endtask

  // Model: k-th hit is judged against tbl[k]; run ends at exp_count hits or first miss when stopping.
  task automatic test_random();
    logic [7:0] tbl [4];
    logic [7:0] d, a;
    int cnt, k, m, e, fi, sof;
    logic [7:0] fd;
    bit fin;
    for (int run = 0; run < 25; run++) begin
      do_reset();
      for (int i = 0; i < 4; i++) begin
        tbl[i] = 8'($urandom_range(0, 255));
        load(2'(i), tbl[i]);
      end
      cnt = $urandom_range(1, 4); sof = $urandom_range(0, 1);
      do_start(3'(cnt), 1'(sof));
      k = 0; m = 0; e = 0; fi = 0; fd = '0; fin = 1'b0;
      while (!fin) begin
        if ($urandom_range(0, 9) < 3) begin
          if ($urandom_range(0, 1) == 0) bwrite(1'b0, DEF_WATCH_ADR, tbl[k]);
          else begin
            a = 8'($urandom_range(0, 254));
            bwrite(1'b1, a, tbl[k]);
          end
        end else begin
          d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : tbl[k];
          if (d == tbl[k]) m++;
          else begin
            if (e == 0) begin fi = k; fd = d; end
            e++;
          end
          k++;
          fin = (k == cnt) || (sof != 0 && d != tbl[k-1]);
          bwrite(1'b1, DEF_WATCH_ADR, d);
        end
      end
      n_vec++;
      if ({busy, done, pass, timeout, match_cnt, err_cnt} !==
          {((e == 0) ? S_PASS : S_FAIL), 3'(m), 8'(e)}) begin
        n_err++; $display("FAIL rnd%0d_result got st=%b m=%0d e=%0d want pass=%0d m=%0d e=%0d",
                          run, {busy, done, pass, timeout}, match_cnt, err_cnt, (e == 0), m, e);
      end
      if (e != 0) begin
        n_vec++;
        if ({fail_idx, fail_data} !== {2'(fi), fd}) begin
          n_err++; $display("FAIL rnd%0d_firstmiss got fi=%0d fd=%h want fi=%0d fd=%h",
                            run, fail_idx, fail_data, fi, fd);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; watch_adr = DEF_WATCH_ADR; exp_we = 1'b0; exp_idx = '0; exp_data = '0;
    exp_count = '0; stop_on_fail = 1'b0; start = 1'b0;
    bus.memwrite = 1'b0; bus.adr = '0; bus.writedata = '0;
    test_reset();
    test_single_pass();
    test_stop_on_fail();
    test_multi();
    test_timeout();
    test_nonhits_late_pass();
    test_reset_mid_run();
    test_exp_we_in_run();
    test_bad_count();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Parametrised, synthesisable self-checking monitor for the mips_mem memory interface. Replaces a single hard-wired "address FF must receive 0D" check.
- Watches memwrite/adr/writedata at a runtime-selected watch address.
- Compares each write there, in order, against a loaded table of up to DEPTH expected values.
- Reports pass, fail or timeout with diagnostic counters.
- Sits beside mips_mem in test tops and on-chip self-test wrappers.

Parameters:
WIDTH, 8, data and address width (matches mips WIDTH)
DEPTH, 4, number of expected-value table entries
IDXBITS, 2, log2(DEPTH)
TIMEOUT, 300, maximum cycles in RUN before timeout (must be ≥ 1)
CNTBITS, 16, width of the internal cycle counter
ERRBITS, 8, width of err_cnt (saturating)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
memwrite  in  1  memory write strobe from mips
adr  in  WIDTH  memory address from mips
writedata  in  WIDTH  write data from mips
watch_adr  in  WIDTH  address whose writes are checked
exp_we  in  1  table load strobe
exp_idx  in  IDXBITS  table load index
exp_data  in  WIDTH  table load value
exp_count  in  IDXBITS+1  number of expected writes, legal range 1..DEPTH
stop_on_fail  in  1  1 = end on first mismatch; 0 = run to exp_count
start  in  1  begin a check run
busy  out  1  high in RUN
done  out  1  high in PASS, FAIL or TOUT
pass  out  1  high only in PASS
timeout  out  1  high only in TOUT
match_cnt  out  IDXBITS+1  number of matching writes
err_cnt  out  ERRBITS  number of mismatching writes; saturates at all-ones
fail_idx  out  IDXBITS  table index of the first mismatch
fail_data  out  WIDTH  writedata of the first mismatch

Behaviour:
- States: IDLE, RUN, PASS, FAIL, TOUT. All outputs are registered and derived from state and counters.
- Reset (at a posedge with reset=1): state←IDLE; all outputs 0; table, index and cycle counter cleared.
- A reset mid-RUN aborts the run with no residual state.

IDLE:
- exp_we writes table[exp_idx]←exp_data. exp_we is ignored in every other state.
- On start: if exp_count is in 1..DEPTH, go to RUN and clear idx, counters, fail_idx and fail_data.
- On start with exp_count=0 or exp_count>DEPTH: go to FAIL, err_cnt←1.

RUN:
- A hit is memwrite=1 AND adr==watch_adr, sampled at posedge.
- Non-hits are ignored, including memwrite=0 with a matching adr.
- Hit with writedata==table[idx]: match_cnt+1, idx+1.
- Hit with writedata≠table[idx]: err_cnt+1 (saturating), idx+1.
- On the first mismatch of the run, latch fail_idx←idx and fail_data←writedata.
- If stop_on_fail=1, a mismatch sends the block to FAIL on the same edge.
- When the hit brings idx to exp_count: go to PASS if the updated err_cnt is 0, otherwise FAIL.
- Cycle counter: 0 on entry to RUN, increments every RUN cycle. When it equals TIMEOUT-1 with no completion on that edge, go to TOUT.
- A completing hit on the timeout edge takes priority over timeout.
- Latency: done/pass is visible in the cycle after the edge that sampled the completing write.
- start is ignored while in RUN.

PASS, FAIL, TOUT:
- Terminal states; outputs hold.
- start re-enters RUN using the current table, with the same exp_count legality check as IDLE.
- reset returns the block to IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE=0, RUN=1, PASS=2, FAIL=3, TOUT=4, 3 bits) and the default watch address 8'hFF.
- One sub-module, chk_table: DEPTH×WIDTH register file with one synchronous write port (clk, reset clears all entries) and one combinational read port indexed by idx.

Test Plan:
1. Load table[0]=0x0D, exp_count=1, watch_adr=FF, start. Write FF←0D at cycle 10 → next cycle done=1, pass=1, match_cnt=1, err_cnt=0.
2. Same setup with stop_on_fail=1, write FF←0C → FAIL, err_cnt=1, fail_idx=0, fail_data=0C, pass=0.
3. Table 01,02,03,05, exp_count=4, stop_on_fail=0. Writes FF←01,02,04,05 → FAIL only after the 4th write, match_cnt=3, err_cnt=1, fail_idx=2, fail_data=04.
4. TIMEOUT=300, no hits after start → done=1 and timeout=1 exactly 300 cycles after the start edge; pass=0.
5. Inject writes to FE and 00, plus memwrite=0 with adr=FF → counters unchanged. Then a matching final hit on the TIMEOUT-1 edge → PASS, not TOUT.
6. Each of the following, checked independently:
   - reset asserted mid-RUN → next cycle all outputs 0, state IDLE.
   - exp_we during RUN → table unchanged.
   - start with exp_count=0 → FAIL with err_cnt=1.
